abs_pos_hls_scheduler: RTL and testbench
========================================

Name: abs_pos_hls_scheduler

Overview:
Round-robin scheduler that shares one HLS absolute-position calculation core among NUM_AXES encoder axes. It latches per-axis calculation requests, selects the next axis fairly, and drives that axis's operands to the core. It runs the core's start/ready/done handshake and returns each 64-bit result tagged with its axis index. A timeout watchdog stops a hung core from blocking the other axes.

Parameters:
NUM_AXES, 4, number of requesting axes (2..8)
AXIS_IDX_W, 2, width of axis index; must satisfy 2**AXIS_IDX_W >= NUM_AXES
TIMEOUT_CYCLES, 255, maximum cycles in WAIT before abort (1..65535)
REFRESH_CYCLES, 1000, auto-refresh period in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
enable  in  1  scheduler enable
axis_req  in  NUM_AXES  per-axis request pulses, one bit per axis
axis_hw_counter  in  NUM_AXES*32  flattened hardware counters; axis i occupies [32*i+31:32*i]
axis_set_position_part1  in  NUM_AXES*32  flattened set-position, low word
axis_set_position_part2  in  NUM_AXES*32  flattened set-position, high word
axis_counts_per_m  in  NUM_AXES*32  flattened counts-per-metre
hls_ready  in  1  core accepts start
hls_done  in  1  core result valid, single-cycle pulse
hls_abs_pos  in  64  core result
start_hls_calculations  out  1  start request to core
selected_axis_hw_counter  out  32  registered operand to core
selected_axis_set_position_part1  out  32  registered operand to core
selected_axis_set_position_part2  out  32  registered operand to core
selected_axis_counts_per_m  out  32  registered operand to core
abs_pos_valid  out  1  one-cycle result strobe
abs_pos_axis  out  AXIS_IDX_W  axis index of the result
abs_pos_data  out  64  result data
busy  out  1  high whenever state != IDLE
state  out  3  current FSM state encoding
timeout_err  out  1  sticky timeout flag
timeout_axis  out  AXIS_IDX_W  axis index of the most recent timeout
err_clr  in  1  clears timeout_err

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, pending=0, last_served=NUM_AXES-1, state=IDLE.
- Pending register: a bit is set by axis_req[i]=1. It is cleared when axis i completes in STORE or TIMEOUT. If set and clear coincide, the bit stays set, so no request is lost.
- FSM encoding: IDLE=0, SELECT=1, START=2, WAIT=3, STORE=4, TIMEOUT=5.
- IDLE -> SELECT when enable=1 and |pending.
- SELECT (one cycle):
  - Choose the first pending axis searching from last_served+1 upward with wrap-around.
  - Register its four operands onto the selected_* outputs and record sel_idx.
  - Go to START.
- START:
  - start_hls_calculations=1.
  - The first cycle hls_ready=1 is sampled, go to WAIT; start drops the next cycle.
  - If hls_done=1 in that same cycle, go directly to STORE.
- WAIT:
  - A watchdog counter increments from 0 each cycle.
  - hls_done=1 -> STORE, capturing hls_abs_pos.
  - Counter reaches TIMEOUT_CYCLES with no done -> TIMEOUT. If done and the limit coincide, done wins.
- STORE (one cycle):
  - abs_pos_valid=1, abs_pos_axis=sel_idx, abs_pos_data=captured result.
  - abs_pos_data holds until the next STORE.
  - Clear pending[sel_idx], set last_served=sel_idx, go to IDLE.
- TIMEOUT (one cycle):
  - timeout_err=1, timeout_axis=sel_idx.
  - Clear pending[sel_idx], set last_served=sel_idx, go to IDLE.
  - No abs_pos_valid is produced.
- Latency: with hls_ready=1 and the core's done arriving N cycles after the start is accepted, the request-to-valid time is IDLE(1) + SELECT(1) + START(1) + N + STORE.
- Deasserting enable mid-operation: the current operation completes, then the FSM stays in IDLE with pending retained.
- err_clr=1 clears timeout_err. If a timeout sets the flag in the same cycle, set wins.
- Selected operands are stable from SELECT until the next SELECT.
- A stray hls_done outside START/WAIT is ignored.

Optional Feature:
PERIODIC_REFRESH_EN: when defined, a free-running counter (0..REFRESH_CYCLES-1, reset to 0) sets all pending bits each time it wraps, so every axis is refreshed periodically without external requests. When undefined, there is no counter and pending is set only by axis_req.

Test Plan:
- Reset and single request: hold rst=0 for 10 cycles, release, enable=1. Pulse axis_req=4'b0010 with axis1 counter=32'h100; core gives ready=1 and done 3 cycles later with abs_pos=64'hDEAD_BEEF. Expect selected_axis_hw_counter=32'h100, then one abs_pos_valid with abs_pos_axis=1 and abs_pos_data=64'hDEAD_BEEF, then busy=0.
- Fairness: pulse axis_req=4'b1111 once. Expect results in axis order 0,1,2,3. Then re-request 4'b0011 while axis 0 is last served; expect order 1,0.
- Ready stall: hold hls_ready=0 for 7 cycles in START. Expect start_hls_calculations high for all 8 cycles and low the cycle after ready=1.
- Timeout: TIMEOUT_CYCLES=16, core never asserts done. Expect timeout_err=1 and timeout_axis equal to the selected axis 16 cycles into WAIT, no abs_pos_valid, and the next pending axis served afterwards. Pulse err_clr -> timeout_err=0.
- Request during service: re-pulse axis_req[2] in the same cycle axis 2 is in STORE. Expect pending[2] to stay set and axis 2 served again.
- Async reset mid-WAIT: drive rst=0 between clock edges. Expect all outputs 0 and state=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/abs_pos_hls_scheduler.sv
// Round-robin scheduler sharing one HLS absolute-position core among NUM_AXES axes.
// Optional build macro PERIODIC_REFRESH_EN re-arms every axis each REFRESH_CYCLES cycles.
module abs_pos_hls_scheduler #(
    parameter int unsigned NUM_AXES       = 4,
    parameter int unsigned AXIS_IDX_W     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned REFRESH_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_AXES-1:0]      axis_req,
    input  logic [NUM_AXES*32-1:0]   axis_hw_counter,
    input  logic [NUM_AXES*32-1:0]   axis_set_position_part1,
    input  logic [NUM_AXES*32-1:0]   axis_set_position_part2,
    input  logic [NUM_AXES*32-1:0]   axis_counts_per_m,
    input  logic                     hls_ready,
    input  logic                     hls_done,
    input  logic [63:0]              hls_abs_pos,
    output logic                     start_hls_calculations,
    output logic [31:0]              selected_axis_hw_counter,
    output logic [31:0]              selected_axis_set_position_part1,
    output logic [31:0]              selected_axis_set_position_part2,
    output logic [31:0]              selected_axis_counts_per_m,
    output logic                     abs_pos_valid,
    output logic [AXIS_IDX_W-1:0]    abs_pos_axis,
    output logic [63:0]              abs_pos_data,
    output logic                     busy,
    output logic [2:0]               state,
    output logic                     timeout_err,
    output logic [AXIS_IDX_W-1:0]    timeout_axis,
    input  logic                     err_clr
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        STORE   = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

    if (NUM_AXES < 2 || NUM_AXES > 8 || (2 ** AXIS_IDX_W) < NUM_AXES ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || REFRESH_CYCLES < 1) begin : g_bad_params
        $error("abs_pos_hls_scheduler: illegal parameter combination");
    end

    state_t                cur_state, next_state;
    logic [NUM_AXES-1:0]   pending, pending_next, clr_mask, refresh_mask;
    logic [AXIS_IDX_W-1:0] last_served, sel_idx, pick;
    logic [15:0]           wd_cnt;
    logic [31:0]           hw_arr   [NUM_AXES];
    logic [31:0]           sp1_arr  [NUM_AXES];
    logic [31:0]           sp2_arr  [NUM_AXES];
    logic [31:0]           cpm_arr  [NUM_AXES];

    always_comb begin
        for (int unsigned i = 0; i < NUM_AXES; i++) begin
            hw_arr[i]  = axis_hw_counter[32*i +: 32];
            sp1_arr[i] = axis_set_position_part1[32*i +: 32];
            sp2_arr[i] = axis_set_position_part2[32*i +: 32];
            cpm_arr[i] = axis_counts_per_m[32*i +: 32];
        end
    end

    // Search starts just past the last served axis so every pending axis waits at most NUM_AXES-1 turns.
    always_comb begin
        logic                  found;
        int unsigned           cand;
        logic [AXIS_IDX_W-1:0] cand_idx;
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 1; k <= NUM_AXES; k++) begin
            cand     = (32'(last_served) + k) % NUM_AXES;
            cand_idx = AXIS_IDX_W'(cand);
            if (!found && pending[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
    end

`ifdef PERIODIC_REFRESH_EN
    logic [31:0] refresh_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
        end else if (refresh_cnt == 32'(REFRESH_CYCLES - 1)) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 32'd1;
        end
    end

    assign refresh_mask = (refresh_cnt == 32'(REFRESH_CYCLES - 1)) ? '1 : '0;
`else
    assign refresh_mask = '0;
`endif

    // A new request in the completing cycle is OR-ed in after the clear, so it survives.
    always_comb begin
        clr_mask = '0;
        if (cur_state == STORE || cur_state == TIMEOUT) begin
            clr_mask[sel_idx] = 1'b1;
        end
        pending_next = (pending & ~clr_mask) | axis_req | refresh_mask;
    end

    always_comb begin
        next_state             = cur_state;
        start_hls_calculations = 1'b0;
        abs_pos_valid          = 1'b0;
        busy                   = (cur_state != IDLE);
        state                  = cur_state;
        case (cur_state)
            IDLE:    if (enable && |pending) next_state = SELECT;
            SELECT:  next_state = START;
            START: begin
                start_hls_calculations = 1'b1;
                if (hls_ready) next_state = hls_done ? STORE : WAIT;
            end
            WAIT: begin
                if (hls_done) begin
                    next_state = STORE;
                end else if (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    next_state = TIMEOUT;
                end
            end
            STORE: begin
                abs_pos_valid = 1'b1;
                next_state    = IDLE;
            end
            TIMEOUT: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state                        <= IDLE;
            pending                          <= '0;
            last_served                      <= AXIS_IDX_W'(NUM_AXES - 1);
            sel_idx                          <= '0;
            wd_cnt                           <= '0;
            selected_axis_hw_counter         <= '0;
            selected_axis_set_position_part1 <= '0;
            selected_axis_set_position_part2 <= '0;
            selected_axis_counts_per_m       <= '0;
            abs_pos_axis                     <= '0;
            abs_pos_data                     <= '0;
            timeout_err                      <= 1'b0;
            timeout_axis                     <= '0;
        end else begin
            cur_state <= next_state;
            pending   <= pending_next;
            wd_cnt    <= (cur_state == WAIT) ? wd_cnt + 16'd1 : '0;

            if (cur_state == SELECT) begin
                sel_idx                          <= pick;
                selected_axis_hw_counter         <= hw_arr[pick];
                selected_axis_set_position_part1 <= sp1_arr[pick];
                selected_axis_set_position_part2 <= sp2_arr[pick];
                selected_axis_counts_per_m       <= cpm_arr[pick];
            end

            if (next_state == STORE) begin
                abs_pos_data <= hls_abs_pos;
                abs_pos_axis <= sel_idx;
            end

            if (cur_state == STORE || cur_state == TIMEOUT) begin
                last_served <= sel_idx;
            end

            if (next_state == TIMEOUT) begin
                timeout_err  <= 1'b1;
                timeout_axis <= sel_idx;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_abs_pos_hls_scheduler.sv
// Directed bench for abs_pos_hls_scheduler: the bench plays the HLS core and checks each handshake.
module tb_abs_pos_hls_scheduler;

    localparam int TO = 16;

    logic         clk, rst, enable, hls_ready, hls_done, err_clr;
    logic [3:0]   axis_req;
    logic [127:0] axis_hw_counter, axis_set_position_part1, axis_set_position_part2, axis_counts_per_m;
    logic [63:0]  hls_abs_pos;
    logic         start_hls_calculations, abs_pos_valid, busy, timeout_err;
    logic [31:0]  selected_axis_hw_counter, selected_axis_set_position_part1;
    logic [31:0]  selected_axis_set_position_part2, selected_axis_counts_per_m;
    logic [1:0]   abs_pos_axis, timeout_axis;
    logic [63:0]  abs_pos_data;
    logic [2:0]   state;

    int assert_count = 0;
    int fail_count   = 0;
    int waited;
    logic [31:0] hw_tab [4] = '{32'h0000_0050, 32'h0000_0100, 32'h0000_0300, 32'h0000_0400};

    abs_pos_hls_scheduler #(
        .NUM_AXES(4), .AXIS_IDX_W(2), .TIMEOUT_CYCLES(TO), .REFRESH_CYCLES(1000)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .axis_req(axis_req),
        .axis_hw_counter(axis_hw_counter),
        .axis_set_position_part1(axis_set_position_part1),
        .axis_set_position_part2(axis_set_position_part2),
        .axis_counts_per_m(axis_counts_per_m),
        .hls_ready(hls_ready), .hls_done(hls_done), .hls_abs_pos(hls_abs_pos),
        .start_hls_calculations(start_hls_calculations),
        .selected_axis_hw_counter(selected_axis_hw_counter),
        .selected_axis_set_position_part1(selected_axis_set_position_part1),
        .selected_axis_set_position_part2(selected_axis_set_position_part2),
        .selected_axis_counts_per_m(selected_axis_counts_per_m),
        .abs_pos_valid(abs_pos_valid), .abs_pos_axis(abs_pos_axis), .abs_pos_data(abs_pos_data),
        .busy(busy), .state(state), .timeout_err(timeout_err), .timeout_axis(timeout_axis),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pulse_req(input logic [3:0] r);
        axis_req = r;
        @(negedge clk);
        axis_req = '0;
    endtask

    // Plays the core for one transaction: stall ready, then done after lat WAIT cycles (0 = same cycle).
    task automatic run_core(input int exp_axis, input int ready_delay, input int lat,
                            input logic [63:0] data, input bit hang, input logic [3:0] store_req,
                            output int wt);
        int wait_cycles;
        int valid_seen;
        wt = 0;
        while (!start_hls_calculations && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        check("start_seen", start_hls_calculations, 1);
        check("op_hw", selected_axis_hw_counter, hw_tab[exp_axis]);
        check("op_sp1", selected_axis_set_position_part1, 32'hA000_0000 + exp_axis);
        check("op_sp2", selected_axis_set_position_part2, 32'hB000_0000 + exp_axis);
        check("op_cpm", selected_axis_counts_per_m, 32'hC000_0000 + exp_axis);
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            check("start_hold", start_hls_calculations, 1);
        end
        hls_ready = 1'b1;
        if (lat == 0 && !hang) begin
            hls_done    = 1'b1;
            hls_abs_pos = data;
        end
        @(negedge clk);
        hls_ready = 1'b0;
        hls_done  = 1'b0;
        check("start_drop", start_hls_calculations, 0);
        if (hang) begin
            wait_cycles = 0;
            valid_seen  = 0;
            while (state == 3'd3 && wait_cycles < 100) begin
                wait_cycles++;
                if (abs_pos_valid) valid_seen++;
                @(negedge clk);
            end
            check("wd_cycles", wait_cycles, TO);
            check("to_state", state, 5);
            check("to_err", timeout_err, 1);
            check("to_axis", timeout_axis, exp_axis);
            check("to_novalid", valid_seen + int'(abs_pos_valid), 0);
        end else begin
            if (lat > 0) begin
                check("wait_state", state, 3);
                repeat (lat - 1) @(negedge clk);
                hls_done    = 1'b1;
                hls_abs_pos = data;
                @(negedge clk);
                hls_done = 1'b0;
            end
            check("store_state", state, 4);
            check("valid", abs_pos_valid, 1);
            check("res_axis", abs_pos_axis, exp_axis);
            check("res_data", abs_pos_data, data);
        end
        axis_req = store_req;
        @(negedge clk);
        axis_req = '0;
        check("valid_drop", abs_pos_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            axis_hw_counter[32*i +: 32]         = hw_tab[i];
            axis_set_position_part1[32*i +: 32] = 32'hA000_0000 + 32'(i);
            axis_set_position_part2[32*i +: 32] = 32'hB000_0000 + 32'(i);
            axis_counts_per_m[32*i +: 32]       = 32'hC000_0000 + 32'(i);
        end
        rst = 1'b0; enable = 1'b0; hls_ready = 1'b0; hls_done = 1'b0; err_clr = 1'b0;
        axis_req = '0; hls_abs_pos = '0;
        repeat (10) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_start", start_hls_calculations, 0);
        check("rst_valid", abs_pos_valid, 0);
        check("rst_data", abs_pos_data, 0);
        check("rst_op", selected_axis_hw_counter, 0);
        check("rst_toerr", timeout_err, 0);
        rst = 1'b1;
        enable = 1'b1;

        // single request, done three cycles after acceptance
        pulse_req(4'b0010);
        run_core(1, 0, 3, 64'hDEAD_BEEF, 0, 4'b0000, waited);
        check("lat_req_to_start", waited, 2);
        check("busy_after", busy, 0);

        hls_done = 1'b1;
        @(negedge clk);
        hls_done = 1'b0;
        check("stray_state", state, 0);
        check("stray_valid", abs_pos_valid, 0);
        check("data_hold", abs_pos_data, 64'hDEAD_BEEF);

        // fairness from reset: last served = 3
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pulse_req(4'b1111);
        run_core(0, 0, 0, 64'h1111_0000_0000_0000, 0, 4'b0000, waited);
        run_core(1, 0, 1, 64'h1111_0000_0000_0001, 0, 4'b0000, waited);
        run_core(2, 0, 2, 64'h1111_0000_0000_0002, 0, 4'b0000, waited);
        run_core(3, 0, 5, 64'h1111_0000_0000_0003, 0, 4'b0000, waited);
        pulse_req(4'b0001);
        run_core(0, 0, 1, 64'h2222_0000_0000_0000, 0, 4'b0000, waited);
        pulse_req(4'b0011);
        run_core(1, 0, 1, 64'h3333_0000_0000_0001, 0, 4'b0000, waited);
        run_core(0, 0, 1, 64'h3333_0000_0000_0000, 0, 4'b0000, waited);

        // ready held low for 7 START cycles
        pulse_req(4'b0100);
        run_core(2, 7, 2, 64'h4444_0000_0000_0002, 0, 4'b0000, waited);

        // axis 3 hangs, axis 0 must still be served
        pulse_req(4'b1001);
        run_core(3, 0, 0, 64'h0, 1, 4'b0000, waited);
        run_core(0, 0, 1, 64'h5555_0000_0000_0000, 0, 4'b0000, waited);
        check("to_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_cleared", timeout_err, 0);

        // request for axis 2 arriving in its own STORE cycle
        pulse_req(4'b0100);
        run_core(2, 0, 1, 64'h6666_0000_0000_0002, 0, 4'b0100, waited);
        run_core(2, 0, 1, 64'h7777_0000_0000_0002, 0, 4'b0000, waited);
        check("rereq_latency", waited, 2);

        // enable low keeps the request pending
        enable = 1'b0;
        pulse_req(4'b0001);
        repeat (5) @(negedge clk);
        check("dis_state", state, 0);
        check("dis_busy", busy, 0);
        enable = 1'b1;
        run_core(0, 0, 1, 64'h8888_0000_0000_0000, 0, 4'b0000, waited);

        // asynchronous reset in the middle of WAIT
        pulse_req(4'b0010);
        hls_ready = 1'b1;
        waited = 0;
        while (state != 3'd3 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        hls_ready = 1'b0;
        check("reach_wait", state, 3);
        #2 rst = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_busy", busy, 0);
        check("arst_start", start_hls_calculations, 0);
        check("arst_op", selected_axis_hw_counter, 0);
        check("arst_data", abs_pos_data, 0);
        check("arst_valid", abs_pos_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_idle", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
